// File: rtl/sdram_pkg.sv
// Shared SDRAM types: pin-level command encodings, init sequencer states and the
// mode-register word builder.
package sdram_pkg;

  // {CS_N, RAS_N, CAS_N, WE_N}
  typedef enum logic [3:0] {
    CmdNop         = 4'b0111,
    CmdActive      = 4'b0011,
    CmdRead        = 4'b0101,
    CmdWrite       = 4'b0100,
    CmdPrecharge   = 4'b0010,
    CmdAutoRefresh = 4'b0001,
    CmdLoadMode    = 4'b0000
  } sdram_cmd_e;

  typedef enum logic [3:0] {
    StIdle,
    StPwrup,
    StPrech,
    StWaitRp,
    StRef,
    StWaitRfc,
    StLmr,
    StWaitMrd,
    StDone
  } init_state_e;

  function automatic logic [12:0] mode_reg(input int unsigned cl, input int unsigned bl,
                                           input logic interleave, input logic write_single);
    logic [2:0] bl_code;
    logic [2:0] cl_code;
    case (bl)
      1:       bl_code = 3'd0;
      2:       bl_code = 3'd1;
      4:       bl_code = 3'd2;
      default: bl_code = 3'd3;
    endcase
    cl_code = 3'(cl);
    return {3'b000, write_single, 2'b00, cl_code, interleave, bl_code};
  endfunction

endpackage

// File: rtl/sdram_init_ctrl_if.sv
// Handshake and SDRAM pin bundle between the init sequencer and the pin mux.
interface sdram_init_ctrl_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned BA_W   = 2
);
  logic              enable;
  logic              busy;
  logic              done;
  logic              DRAM_CLK;
  logic              DRAM_CKE;
  logic              DRAM_CS_N;
  logic              DRAM_RAS_N;
  logic              DRAM_CAS_N;
  logic              DRAM_WE_N;
  logic              DRAM_LDQM;
  logic              DRAM_UDQM;
  logic [ADDR_W-1:0] DRAM_ADDR;
  logic [BA_W-1:0]   DRAM_BA;

  modport master (
    input  enable,
    output busy, done, DRAM_CLK, DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N,
           DRAM_LDQM, DRAM_UDQM, DRAM_ADDR, DRAM_BA
  );

  modport slave (
    output enable,
    input  busy, done, DRAM_CLK, DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N,
           DRAM_LDQM, DRAM_UDQM, DRAM_ADDR, DRAM_BA
  );
endinterface

// File: rtl/sdram_wait_timer.sv
// Loadable down-counter; holds at zero and flags it.
module sdram_wait_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             zero_o
);
  logic [Width-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up init sequencer: power-up wait, PRECHARGE ALL, N x AUTO REFRESH,
// LOAD MODE, then a sticky done while enable stays high.
module sdram_init_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned CLK_PERIOD_NS    = 20,
  parameter int unsigned POWERUP_NS       = 200000,
  parameter int unsigned TRP_CYC          = 2,
  parameter int unsigned TRFC_CYC         = 8,
  parameter int unsigned TMRD_CYC         = 2,
  parameter int unsigned REFRESH_COUNT    = 2,
  parameter int unsigned CAS_LATENCY      = 2,
  parameter int unsigned BURST_LEN        = 4,
  parameter bit          BURST_INTERLEAVE = 1'b0,
  parameter bit          WRITE_SINGLE     = 1'b0,
  parameter int unsigned ADDR_W           = 13,
  parameter int unsigned BA_W             = 2
) (
  input logic                 clock,
  input logic                 reset,
  sdram_init_ctrl_if.master   bus
);
  localparam int unsigned POWERUP_CYC =
      (CLK_PERIOD_NS == 0) ? 1 : (POWERUP_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
  localparam int unsigned MaxA   = (POWERUP_CYC > TRFC_CYC) ? POWERUP_CYC : TRFC_CYC;
  localparam int unsigned MaxB   = (TRP_CYC > TMRD_CYC) ? TRP_CYC : TMRD_CYC;
  localparam int unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned TW     = $clog2(MaxCyc + 1);

  // Loads are cycles-1: the entry edge itself counts as the first cycle.
  localparam logic [TW-1:0] PwrLoad  = TW'(POWERUP_CYC - 1);
  localparam logic [TW-1:0] RpLoad   = TW'(TRP_CYC - 1);
  localparam logic [TW-1:0] RfcLoad  = TW'(TRFC_CYC - 1);
  localparam logic [TW-1:0] MrdLoad  = TW'(TMRD_CYC - 1);
  localparam logic [12:0]   ModeWord =
      mode_reg(CAS_LATENCY, BURST_LEN, BURST_INTERLEAVE, WRITE_SINGLE);

  if (CAS_LATENCY != 2 && CAS_LATENCY != 3) begin : g_bad_cl
    $error("sdram_init_ctrl: CAS_LATENCY must be 2 or 3");
  end
  if (BURST_LEN != 1 && BURST_LEN != 2 && BURST_LEN != 4 && BURST_LEN != 8) begin : g_bad_bl
    $error("sdram_init_ctrl: BURST_LEN must be 1, 2, 4 or 8");
  end
  if (REFRESH_COUNT < 1 || REFRESH_COUNT > 15) begin : g_bad_ref
    $error("sdram_init_ctrl: REFRESH_COUNT must be 1..15");
  end
  if (ADDR_W < 11) begin : g_bad_aw
    $error("sdram_init_ctrl: ADDR_W must be at least 11");
  end
  if (CLK_PERIOD_NS == 0 || POWERUP_NS == 0 || TRP_CYC == 0 || TRFC_CYC == 0 ||
      TMRD_CYC == 0) begin : g_bad_tim
    $error("sdram_init_ctrl: timing parameters must be non-zero");
  end

  init_state_e       state_q, state_d;
  sdram_cmd_e        cmd_q, cmd_d;
  logic              cke_q, cke_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic [3:0]        ref_cnt_q, ref_cnt_d;
  logic              tmr_load, tmr_zero;
  logic [TW-1:0]     tmr_value;

  sdram_wait_timer #(.Width(TW)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .zero_o  (tmr_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cmd_q     <= CmdNop;
      cke_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      ba_q      <= '0;
      ref_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cke_q     <= cke_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      ba_q      <= ba_d;
      ref_cnt_q <= ref_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = CmdNop;
    cke_d     = cke_q;
    busy_d    = busy_q;
    done_d    = done_q;
    addr_d    = '0;
    ba_d      = '0;
    ref_cnt_d = ref_cnt_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    if (!bus.enable) begin
      state_d = StIdle;
      cke_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d   = StPwrup;
          cke_d     = 1'b1;
          busy_d    = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = PwrLoad;
        end
        StPwrup: begin
          if (tmr_zero) begin
            state_d    = StPrech;
            cmd_d      = CmdPrecharge;
            addr_d[10] = 1'b1;
            ref_cnt_d  = '0;
            tmr_load   = 1'b1;
            tmr_value  = RpLoad;
          end
        end
        StPrech, StWaitRp, StRef, StWaitRfc: begin
          if (!tmr_zero) begin
            state_d = (state_q == StPrech || state_q == StWaitRp) ? StWaitRp : StWaitRfc;
          end else if (ref_cnt_q == 4'(REFRESH_COUNT)) begin
            state_d   = StLmr;
            cmd_d     = CmdLoadMode;
            addr_d    = ADDR_W'(ModeWord);
            tmr_load  = 1'b1;
            tmr_value = MrdLoad;
          end else begin
            state_d   = StRef;
            cmd_d     = CmdAutoRefresh;
            ref_cnt_d = ref_cnt_q + 4'd1;
            tmr_load  = 1'b1;
            tmr_value = RfcLoad;
          end
        end
        StLmr, StWaitMrd: begin
          if (tmr_zero) begin
            state_d = StDone;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = StWaitMrd;
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.DRAM_CLK   = ~clock;
  assign bus.DRAM_CKE   = cke_q;
  assign {bus.DRAM_CS_N, bus.DRAM_RAS_N, bus.DRAM_CAS_N, bus.DRAM_WE_N} = cmd_q;
  assign bus.DRAM_LDQM  = 1'b1;
  assign bus.DRAM_UDQM  = 1'b1;
  assign bus.DRAM_ADDR  = addr_q;
  assign bus.DRAM_BA    = ba_q;
endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Bench for sdram_init_ctrl: two parameter sets driven by the same enable/reset and
// compared every cycle against a timeline model of the init sequence.
module tb_sdram_init_ctrl;
  logic clock = 1'b0;
  logic reset;
  logic enable;
  int   total = 0;
  int   bad   = 0;
  int   t     = -1;  // edges since sequence start, -1 when idle
  int   n_pre_a, n_ref_a, n_lmr_a, n_pre_b, n_ref_b, n_lmr_b;

  always #5 clock = ~clock;

  sdram_init_ctrl_if #(.ADDR_W(13), .BA_W(2)) if_a ();
  sdram_init_ctrl_if #(.ADDR_W(13), .BA_W(2)) if_b ();
  assign if_a.enable = enable;
  assign if_b.enable = enable;

  sdram_init_ctrl #(.POWERUP_NS(200), .CLK_PERIOD_NS(20)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (if_a.master)
  );

  sdram_init_ctrl #(
    .POWERUP_NS(200), .CLK_PERIOD_NS(20), .REFRESH_COUNT(4), .CAS_LATENCY(3),
    .BURST_LEN(8), .TRFC_CYC(3)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (if_b.master)
  );

  // {cke, cs/ras/cas/we, ldqm/udqm, busy, done, ba, addr}
  logic [23:0] obs_a, obs_b;
  assign obs_a = {if_a.DRAM_CKE, if_a.DRAM_CS_N, if_a.DRAM_RAS_N, if_a.DRAM_CAS_N,
                  if_a.DRAM_WE_N, if_a.DRAM_LDQM, if_a.DRAM_UDQM, if_a.busy, if_a.done,
                  if_a.DRAM_BA, if_a.DRAM_ADDR};
  assign obs_b = {if_b.DRAM_CKE, if_b.DRAM_CS_N, if_b.DRAM_RAS_N, if_b.DRAM_CAS_N,
                  if_b.DRAM_WE_N, if_b.DRAM_LDQM, if_b.DRAM_UDQM, if_b.busy, if_b.done,
                  if_b.DRAM_BA, if_b.DRAM_ADDR};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Pin state expected after the edge numbered t of a sequence.
  function automatic logic [23:0] exp_pins(input int tt, input int p, input int trp,
                                           input int trfc, input int tmrd, input int nref,
                                           input logic [12:0] mode);
    logic [3:0]  cmd  = 4'b0111;
    logic [12:0] addr = '0;
    logic        cke = 1'b0, busy = 1'b0, done = 1'b0;
    int          l;
    if (tt >= 0) begin
      l    = p + trp + nref * trfc;
      cke  = 1'b1;
      done = (tt >= l + tmrd);
      busy = !done;
      if (tt == p) begin
        cmd      = 4'b0010;
        addr[10] = 1'b1;
      end
      for (int k = 0; k < nref; k++) if (tt == p + trp + k * trfc) cmd = 4'b0001;
      if (tt == l) begin
        cmd  = 4'b0000;
        addr = mode;
      end
    end
    return {cke, cmd, 2'b11, busy, done, 2'b00, addr};
  endfunction

  function automatic logic [23:0] exp_a(input int tt);
    return exp_pins(tt, 10, 2, 8, 2, 2, 13'h0022);
  endfunction

  function automatic logic [23:0] exp_b(input int tt);
    return exp_pins(tt, 10, 2, 3, 2, 4, 13'h0033);
  endfunction

  task automatic tally(input logic [3:0] cmd, inout int np, inout int nr, inout int nl);
    if (cmd == 4'b0010) np++;
    if (cmd == 4'b0001) nr++;
    if (cmd == 4'b0000) nl++;
  endtask

  // Drive enable, advance one edge in the model, then compare on the falling edge.
  task automatic step(input logic en);
    enable = en;
    @(posedge clock);
    if (reset || !en) t = -1;
    else if (t < 0) t = 0;
    else t++;
    @(negedge clock);
    check("pins_a", 32'(obs_a), 32'(exp_a(t)));
    check("pins_b", 32'(obs_b), 32'(exp_b(t)));
    check("dram_clk", 32'(if_a.DRAM_CLK), 32'd1);
    if (t == 0) begin
      n_pre_a = 0; n_ref_a = 0; n_lmr_a = 0;
      n_pre_b = 0; n_ref_b = 0; n_lmr_b = 0;
    end
    tally(obs_a[22:19], n_pre_a, n_ref_a, n_lmr_a);
    tally(obs_b[22:19], n_pre_b, n_ref_b, n_lmr_b);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_a", 32'(obs_a), 32'(exp_a(-1)));
    check("reset_b", 32'(obs_b), 32'(exp_b(-1)));
    reset = 1'b0;
    repeat (2) step(1'b0);

    // Uninterrupted sequence on both parameter sets.
    repeat (40) step(1'b1);
    repeat (3) step(1'b0);

    // Enable dropped after edge 15, restarted at edge 20.
    repeat (16) step(1'b1);
    repeat (4) step(1'b0);
    repeat (35) step(1'b1);
    repeat (2) step(1'b0);

    // Asynchronous reset between edges 11 and 12.
    repeat (12) step(1'b1);
    #2 reset = 1'b1;
    t = -1;
    #1;
    check("async_rst_a", 32'(obs_a), 32'(exp_a(-1)));
    check("async_rst_b", 32'(obs_b), 32'(exp_b(-1)));
    @(negedge clock);
    repeat (2) step(1'b1);
    reset = 1'b0;

    // Long hold after done: only NOP, exactly one full set of commands.
    repeat (1040) step(1'b1);
    check("n_pre_a", 32'(n_pre_a), 32'd1);
    check("n_ref_a", 32'(n_ref_a), 32'd2);
    check("n_lmr_a", 32'(n_lmr_a), 32'd1);
    check("n_pre_b", 32'(n_pre_b), 32'd1);
    check("n_ref_b", 32'(n_ref_b), 32'd4);
    check("n_lmr_b", 32'(n_lmr_b), 32'd1);

    // Random enable drop/restart patterns.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(1, 4)) step(1'b0);
      repeat ($urandom_range(1, 45)) step(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_init_ctrl.md
Name: sdram_init_ctrl

Overview:
Parametrised SDRAM power-up initialisation sequencer. Generates the JEDEC init sequence: power-up wait, PRECHARGE ALL, N × AUTO REFRESH, LOAD MODE REGISTER. Timing and mode-register contents come from parameters. Signals completion with a sticky done flag so the future read/write/refresh controller can take over the SDRAM pins via a downstream mux.

Parameters:
CLK_PERIOD_NS, 20, system clock period in ns
POWERUP_NS, 200000, power-up stable wait; POWERUP_CYC = ceil(POWERUP_NS/CLK_PERIOD_NS)
TRP_CYC, 2, PRECHARGE-to-next-command spacing in cycles (>=1)
TRFC_CYC, 8, AUTO REFRESH-to-next-command spacing in cycles (>=1)
TMRD_CYC, 2, LOAD MODE-to-done spacing in cycles (>=1)
REFRESH_COUNT, 2, number of AUTO REFRESH commands (1..15)
CAS_LATENCY, 2, mode register CL (2 or 3)
BURST_LEN, 4, mode register burst length (1, 2, 4, 8)
BURST_INTERLEAVE, 0, mode register A3 (0 = sequential)
WRITE_SINGLE, 0, mode register A9 (1 = single-location write)
ADDR_W, 13, SDRAM address width (>=11)
BA_W, 2, bank address width

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  level; high = run or hold init, low = abort/idle
busy  out  1  high from sequence start until done
done  out  1  sticky high after tMRD following LOAD MODE, while enable stays high
DRAM_CLK  out  1  equals ~clock
DRAM_CKE  out  1  clock enable
DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N  out  1 each  command pins
DRAM_LDQM, DRAM_UDQM  out  1 each  data masks
DRAM_ADDR  out  ADDR_W  address
DRAM_BA  out  BA_W  bank

Behaviour:
- Reset values: state IDLE; CKE=0; command NOP ({CS,RAS,CAS,WE}_N=0111); LDQM=UDQM=1; ADDR=0; BA=0; busy=0; done=0.
- All pin outputs are registered. Command encodings: NOP 0111, PRECHARGE 0010, AUTO REFRESH 0001, LOAD MODE 0000.
- A command is asserted for exactly one cycle. NOP is driven in every other cycle. DQM stays 1 throughout.
- FSM: IDLE -> PWRUP -> PRECH -> WAIT_RP -> REF -> WAIT_RFC -> (REF again if refreshes remain, else LMR) -> WAIT_MRD -> DONE.
- Edge 0 is the first rising edge where enable=1 in IDLE. CKE=1 and busy=1 take effect from edge 0.
- Command timing (pin edges):
  - PRECHARGE at edge P = POWERUP_CYC.
  - AUTO REFRESH k (k = 0..REFRESH_COUNT-1) at P + TRP_CYC + k·TRFC_CYC.
  - LOAD MODE at L = P + TRP_CYC + REFRESH_COUNT·TRFC_CYC.
  - done=1, busy=0 at edge L + TMRD_CYC.
- Address during commands:
  - PRECHARGE: ADDR[10]=1, all other ADDR bits and BA = 0.
  - LOAD MODE: BA=0, ADDR[ADDR_W-1:10]=0, A9=WRITE_SINGLE, A8:7=00, A6:4=CL code, A3=BURST_INTERLEAVE, A2:0=BL code (1->000, 2->001, 4->010, 8->011).
  - All other cycles: ADDR=0, BA=0.
- DONE is terminal while enable=1; no further commands are issued.
- enable low in any state: next edge returns to IDLE with reset output values (CKE=0, done=0, busy=0). An in-flight command is not extended. Re-assertion restarts the full sequence including the power-up wait.
- reset asserted mid-sequence: outputs take reset values immediately (asynchronous). Sequence restarts only after reset release with enable sampled high.
- Counters: a single down-counter of width $clog2(max(POWERUP_CYC, TRFC_CYC, TRP_CYC, TMRD_CYC)+1), reloaded on each state entry; the refresh counter is 4 bits.
- Elaboration: $error on illegal CAS_LATENCY, BURST_LEN, REFRESH_COUNT, or ADDR_W<11, and on any timing parameter of 0.

Decomposition:
- Package sdram_pkg holds:
  - the 4-bit command enum (NOP, PRECHARGE, AUTO_REFRESH, LOAD_MODE, plus ACTIVE, READ, WRITE reserved for the controller);
  - the init-state enum;
  - function mode_reg(cl, bl, interleave, write_single) returning the 13-bit mode word.
- One sub-module, sdram_wait_timer: loadable down-counter with load value, load strobe, and zero flag, parametrised on width.

Test Plan:
- Test parameters POWERUP_NS=200, CLK_PERIOD_NS=20 (POWERUP_CYC=10), other parameters default. Hold enable=1 from edge 0 -> PRECHARGE with ADDR[10]=1 at edge 10; AUTO REFRESH at 12 and 20; LOAD MODE at 28 with {BA,ADDR}=15'h0022; done=1 at 30; NOP on all other edges; CKE=1 from edge 0.
- REFRESH_COUNT=4, CAS_LATENCY=3, BURST_LEN=8, TRFC_CYC=3 -> refreshes at 12, 15, 18, 21; LOAD MODE at 24 with ADDR=13'h0033; done at 26.
- Drop enable at edge 15 (inside WAIT_RFC), re-raise at edge 20 -> CKE=0 and NOP from edge 16; new PRECHARGE at edge 30; done at 50.
- Assert reset asynchronously between edges 11 and 12 -> CKE=0, NOP, and DQM=1 before edge 12; no AUTO REFRESH at edge 12.
- Keep enable high for 1000 cycles after done -> done stays 1; only NOP is issued; exactly 1 PRECHARGE, 2 AUTO REFRESH, and 1 LOAD MODE in total.
- BURST_LEN=3 -> elaboration $error.
